// File: rtl/register_port_sequencer.sv
// ============================================================================
// Module      : register_port_sequencer
// Description : Four-phase instruction sequencer that drives enable,
//               write-enable and byte-lane strobes for NPORTS register-file
//               ports. The optional EXECUTE stall is enabled by defining the
//               macro REGSEQ_STALL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module register_port_sequencer #(
  parameter int NPORTS  = 2,
  parameter int LANES   = 2,
  parameter int LANE_AW = 1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  STALL,
  input  logic [2*NPORTS-1:0]   SEQX,
  input  logic [1:0]            BYTEX,
  input  logic [LANE_AW-1:0]    LANE_ADDR,
  output logic                  FETCH,
  output logic                  DECODE,
  output logic                  EXECUTE,
  output logic                  COMMIT,
  output logic [NPORTS-1:0]     PORT_EN,
  output logic [NPORTS-1:0]     PORT_WEN,
  output logic [LANES-1:0]      PORT0_BYTE_EN,
  output logic                  ILLEGAL
);

  typedef enum logic [1:0] {
    PH_FETCH   = 2'd0,
    PH_DECODE  = 2'd1,
    PH_EXECUTE = 2'd2,
    PH_COMMIT  = 2'd3
  } phase_t;

  phase_t                phase_q, phase_d;
  logic [2*NPORTS-1:0]   seq_q, seq_d;
  logic [1:0]            bytex_q, bytex_d;
  logic [LANE_AW-1:0]    lane_q, lane_d;

  logic                  active;
  logic                  in_commit;
  logic [NPORTS-1:0]     reserved;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      phase_q <= PH_FETCH;
      seq_q   <= '0;
      bytex_q <= '0;
      lane_q  <= '0;
    end else begin
      phase_q <= phase_d;
      seq_q   <= seq_d;
      bytex_q <= bytex_d;
      lane_q  <= lane_d;
    end
  end

`ifndef REGSEQ_STALL_EN
  logic unused_stall;
  assign unused_stall = STALL;
`endif

  always_comb begin
    phase_d = phase_q;
    seq_d   = seq_q;
    bytex_d = bytex_q;
    lane_d  = lane_q;
    case (phase_q)
      PH_FETCH:  phase_d = PH_DECODE;
      PH_DECODE: begin
        // Instruction fields are frozen here for EXECUTE and COMMIT
        phase_d = PH_EXECUTE;
        seq_d   = SEQX;
        bytex_d = BYTEX;
        lane_d  = LANE_ADDR;
      end
      PH_EXECUTE: begin
`ifdef REGSEQ_STALL_EN
        phase_d = STALL ? PH_EXECUTE : PH_COMMIT;
`else
        phase_d = PH_COMMIT;
`endif
      end
      PH_COMMIT: phase_d = PH_FETCH;
      default:   phase_d = PH_FETCH;
    endcase
  end

  assign FETCH     = (phase_q == PH_FETCH);
  assign DECODE    = (phase_q == PH_DECODE);
  assign EXECUTE   = (phase_q == PH_EXECUTE);
  assign COMMIT    = (phase_q == PH_COMMIT);
  assign active    = EXECUTE || COMMIT;
  assign in_commit = COMMIT;

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    logic [1:0] code;
    assign code        = seq_q[2*p +: 2];
    assign PORT_EN[p]  = active && ((code == 2'b01) || (code == 2'b10));
    assign PORT_WEN[p] = in_commit && (code == 2'b10);
    assign reserved[p] = (code == 2'b11);
  end

  assign ILLEGAL = in_commit && (|reserved);

  always_comb begin
    PORT0_BYTE_EN = '0;
    if (active) begin
      case (seq_q[1:0])
        2'b01: PORT0_BYTE_EN = '1;
        2'b10: begin
          case (bytex_q)
            2'b01: begin
              for (int i = 0; i < LANES; i++)
                PORT0_BYTE_EN[i] = (lane_q == LANE_AW'(i));
            end
            2'b10: begin
              // Half-word only exists with four lanes; otherwise whole word
              if (LANES == 4) begin
                for (int i = 0; i < LANES; i++)
                  PORT0_BYTE_EN[i] = ((i >= 2) == lane_q[LANE_AW-1]);
              end else begin
                PORT0_BYTE_EN = '1;
              end
            end
            default: PORT0_BYTE_EN = '1;
          endcase
        end
        default: PORT0_BYTE_EN = '0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_register_port_sequencer.sv
// ============================================================================
// Module      : tb_register_port_sequencer
// Description : Table-driven bench for register_port_sequencer, run against a
//               LANES=2 and a LANES=4 instance sharing one stimulus stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_register_port_sequencer;

  logic       clk = 1'b0;
  logic       rst_in;
  logic       stall;
  logic [3:0] seqx;
  logic [1:0] bytex;
  logic [1:0] lane;

  logic       f2, d2, e2, c2, ill2;
  logic [1:0] en2, wen2, be2;
  logic       f4, d4, e4, c4, ill4;
  logic [1:0] en4, wen4;
  logic [3:0] be4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  register_port_sequencer #(.NPORTS(2), .LANES(2), .LANE_AW(1)) dut2 (
    .CLK(clk), .RESET(rst_in), .STALL(stall), .SEQX(seqx), .BYTEX(bytex),
    .LANE_ADDR(lane[0]), .FETCH(f2), .DECODE(d2), .EXECUTE(e2), .COMMIT(c2),
    .PORT_EN(en2), .PORT_WEN(wen2), .PORT0_BYTE_EN(be2), .ILLEGAL(ill2)
  );

  register_port_sequencer #(.NPORTS(2), .LANES(4), .LANE_AW(2)) dut4 (
    .CLK(clk), .RESET(rst_in), .STALL(stall), .SEQX(seqx), .BYTEX(bytex),
    .LANE_ADDR(lane), .FETCH(f4), .DECODE(d4), .EXECUTE(e4), .COMMIT(c4),
    .PORT_EN(en4), .PORT_WEN(wen4), .PORT0_BYTE_EN(be4), .ILLEGAL(ill4)
  );

  typedef struct {
    logic [3:0] seqx;
    logic [1:0] bytex;
    logic [1:0] lane;
    int         stall;
    logic [1:0] en;
    logic [1:0] wen;
    logic [1:0] be2;
    logic [3:0] be4;
    logic       ill;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] ph, input logic [1:0] en,
                           input logic [1:0] wen, input logic [1:0] b2, input logic [3:0] b4,
                           input logic ill);
    chk({tag, " phase2"}, 32'({f2, d2, e2, c2}), 32'(ph));
    chk({tag, " phase4"}, 32'({f4, d4, e4, c4}), 32'(ph));
    chk({tag, " en2"},    32'(en2),  32'(en));
    chk({tag, " en4"},    32'(en4),  32'(en));
    chk({tag, " wen2"},   32'(wen2), 32'(wen));
    chk({tag, " wen4"},   32'(wen4), 32'(wen));
    chk({tag, " be2"},    32'(be2),  32'(b2));
    chk({tag, " be4"},    32'(be4),  32'(b4));
    chk({tag, " ill2"},   32'(ill2), 32'(ill));
    chk({tag, " ill4"},   32'(ill4), 32'(ill));
  endtask

  // Entered and left at a falling edge with the DUTs in FETCH.
  task automatic run_vec(input vec_t v, input int idx);
    string t;
    t = $sformatf("v%0d", idx);
    check_all({t, " fetch"}, 4'b1000, 2'b00, 2'b00, 2'b00, 4'b0000, 1'b0);
    seqx  = v.seqx;
    bytex = v.bytex;
    lane  = v.lane;
    stall = (v.stall > 0);
    @(negedge clk);
    check_all({t, " decode"}, 4'b0100, 2'b00, 2'b00, 2'b00, 4'b0000, 1'b0);
    @(negedge clk);
    check_all({t, " exec"}, 4'b0010, v.en, 2'b00, v.be2, v.be4, 1'b0);
    seqx  = ~v.seqx;
    bytex = ~v.bytex;
    lane  = ~v.lane;
`ifdef REGSEQ_STALL_EN
    for (int k = 0; k < v.stall; k++) begin
      @(negedge clk);
      check_all({t, " stall"}, 4'b0010, v.en, 2'b00, v.be2, v.be4, 1'b0);
    end
    stall = 1'b0;
`endif
    @(negedge clk);
    check_all({t, " commit"}, 4'b0001, v.en, v.wen, v.be2, v.be4, v.ill);
    stall = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    //            seqx     bytex  lane  stl en     wen    be2    be4      ill
    vecs[0] = '{4'b0000, 2'b00, 2'd0, 0, 2'b00, 2'b00, 2'b00, 4'b0000, 1'b0};
    vecs[1] = '{4'b0101, 2'b01, 2'd0, 0, 2'b11, 2'b00, 2'b11, 4'b1111, 1'b0};
    vecs[2] = '{4'b1010, 2'b01, 2'd1, 0, 2'b11, 2'b11, 2'b10, 4'b0010, 1'b0};
    vecs[3] = '{4'b0010, 2'b10, 2'd2, 3, 2'b01, 2'b01, 2'b11, 4'b1100, 1'b0};
    vecs[4] = '{4'b0010, 2'b01, 2'd3, 0, 2'b01, 2'b01, 2'b10, 4'b1000, 1'b0};
    vecs[5] = '{4'b1110, 2'b00, 2'd0, 0, 2'b01, 2'b01, 2'b11, 4'b1111, 1'b1};
    vecs[6] = '{4'b0011, 2'b01, 2'd1, 0, 2'b00, 2'b00, 2'b00, 4'b0000, 1'b1};
    vecs[7] = '{4'b1001, 2'b10, 2'd1, 2, 2'b11, 2'b10, 2'b11, 4'b1111, 1'b0};
    vecs[8] = '{4'b0010, 2'b11, 2'd1, 0, 2'b01, 2'b01, 2'b11, 4'b1111, 1'b0};
    vecs[9] = '{4'b0010, 2'b10, 2'd1, 0, 2'b01, 2'b01, 2'b11, 4'b0011, 1'b0};

    rst_in = 1'b1;
    stall  = 1'b0;
    seqx   = 4'b0000;
    bytex  = 2'b00;
    lane   = 2'd0;
    repeat (2) @(negedge clk);
    check_all("reset", 4'b1000, 2'b00, 2'b00, 2'b00, 4'b0000, 1'b0);
    rst_in = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Reset asserted in COMMIT must kill the write at once
    seqx  = 4'b1010;
    bytex = 2'b01;
    lane  = 2'd1;
    repeat (3) @(negedge clk);
    check_all("pre_rst commit", 4'b0001, 2'b11, 2'b11, 2'b10, 4'b0010, 1'b0);
    rst_in = 1'b1;
    #1;
    check_all("rst_in_commit", 4'b1000, 2'b00, 2'b00, 2'b00, 4'b0000, 1'b0);
    seqx = 4'b0000;
    @(negedge clk);
    rst_in = 1'b0;
    check_all("rst held", 4'b1000, 2'b00, 2'b00, 2'b00, 4'b0000, 1'b0);
    @(negedge clk);
    check_all("post_rst decode", 4'b0100, 2'b00, 2'b00, 2'b00, 4'b0000, 1'b0);
    @(negedge clk);
    check_all("post_rst exec", 4'b0010, 2'b00, 2'b00, 2'b00, 4'b0000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/register_port_sequencer.md
# register_port_sequencer

Parametrised successor to the two-port register sequencer. Generates its own four-phase instruction cycle (FETCH, DECODE, EXECUTE, COMMIT) with an optional EXECUTE stall. Drives enable, write-enable and byte-lane strobes for NPORTS register-file ports. Sits between the instruction decoder (per-port sequence codes, byte mode, lane address) and the register file.

## Interface
Parameters:
- NPORTS, 2: number of register-file ports; legal range 2..4.
- LANES, 2: byte lanes per register word; legal values 2 or 4.
- LANE_AW, 1: lane-address width; must equal log2(LANES).

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- STALL  in  1  holds EXECUTE while high; only present in behaviour with REGSEQ_STALL_EN.
- SEQX  in  2*NPORTS  per-port sequence code; port p uses bits [2p+1:2p]. 00 = NONE, 01 = READ, 10 = UPDATE, 11 = reserved.
- BYTEX  in  2  width mode for port 0: 00 = WORD, 01 = BYTE, 10 = HALF (LANES=4 only), 11 = reserved, treated as WORD.
- LANE_ADDR  in  LANE_AW  selects the lane for BYTE and HALF modes.
- FETCH, DECODE, EXECUTE, COMMIT  out  1 each  one-hot phase indicators.
- PORT_EN  out  NPORTS  per-port enable.
- PORT_WEN  out  NPORTS  per-port write enable.
- PORT0_BYTE_EN  out  LANES  lane strobes for port 0; ports 1..NPORTS-1 are always whole-word.
- ILLEGAL  out  1  pulses when a reserved SEQX code was captured.

## Operation
- Phase register advances one phase per clock: FETCH → DECODE → EXECUTE → COMMIT → FETCH.
- The only exception to one phase per clock is the stall rule below.
- SEQX, BYTEX and LANE_ADDR are captured at the rising edge that leaves DECODE.
- Captured values are held constant through EXECUTE and COMMIT, so input changes after DECODE have no effect on the current instruction.
- PORT_EN[p] is 1 in EXECUTE and COMMIT when the captured code for port p is READ or UPDATE. It is 0 otherwise, and 0 in FETCH and DECODE.
- PORT_WEN[p] is 1 only in COMMIT, and only when the captured code for port p is UPDATE.
- A reserved code (11) behaves as NONE for that port.
- ILLEGAL is 1 in COMMIT when any port captured a reserved code.

PORT0_BYTE_EN:
- All zeros in FETCH and DECODE, and whenever the port 0 code is NONE or reserved.
- Port 0 READ: all ones; BYTEX is ignored for reads.
- Port 0 UPDATE with WORD: all ones.
- Port 0 UPDATE with BYTE: one-hot, bit LANE_ADDR set.
- Port 0 UPDATE with HALF: LANE_ADDR[1]=0 gives 0011; LANE_ADDR[1]=1 gives 1100.
- HALF when LANES=2: treated as WORD.

Stall:
- STALL is sampled in EXECUTE. If STALL is 1 at the rising edge, the phase stays EXECUTE.
- During a stall, enables and lane strobes hold their EXECUTE values and PORT_WEN stays 0.
- STALL has no effect in any other phase.

## Timing
- All outputs are registered and decoded from the phase register and the captured fields. No combinational path exists from any input to any output.
- RESET asserted: phase goes to FETCH immediately. FETCH=1, every other output 0, captured fields cleared to NONE/WORD/0.
- First rising edge after RESET deasserts: phase goes to DECODE.
- Latency: controls sampled in DECODE appear at the outputs one cycle later (EXECUTE). Writes occur in the following cycle (COMMIT).
- Instruction period: 4 cycles plus the number of stalled cycles.
- RESET asserted mid-instruction (including during COMMIT or a stall): all write enables drop at once. No partial commit survives; the sequence restarts at FETCH.

## Configuration
- REGSEQ_STALL_EN defined: STALL is honoured as described above.
- REGSEQ_STALL_EN undefined: the STALL port still exists but is ignored, and the cycle is a fixed 4 cycles.

## Test plan
- NPORTS=2, LANES=2; SEQX=0000 for one cycle → all four phases occur, and PORT_EN, PORT_WEN and PORT0_BYTE_EN stay 0 throughout.
- SEQX=0101 (both READ), BYTEX=BYTE → EXECUTE and COMMIT give PORT_EN=11, PORT_WEN=00, PORT0_BYTE_EN=11.
- SEQX=1010 (both UPDATE), BYTEX=BYTE, LANE_ADDR=1 → EXECUTE gives PORT_EN=11, WEN=00, BYTE_EN=10; COMMIT gives WEN=11, BYTE_EN=10.
- LANES=4, port 0 UPDATE:
  - HALF, LANE_ADDR=2 → BYTE_EN=1100 in COMMIT.
  - BYTE, LANE_ADDR=3 → BYTE_EN=1000 in COMMIT.
- REGSEQ_STALL_EN defined, port 0 UPDATE, STALL=1 for 3 EXECUTE cycles → EXECUTE lasts 4 cycles with WEN=0, then one COMMIT with WEN[0]=1.
  - Same stimulus with the macro undefined → COMMIT follows after exactly 1 EXECUTE cycle.
- Reserved code 11 on port 1 → PORT_EN[1]=0 throughout and ILLEGAL=1 only in COMMIT.
  - RESET asserted during COMMIT → all outputs 0 and FETCH=1 in the same cycle.
